// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage.
//   ctx_state_t  : pipeline position of a context (S_FETCH, S_DECODE, ...)
//   exc_code_t   : exception cause codes (EX_ADEL = misaligned fetch/load)
//   context_t    : the per-instruction context passed between stages
//   ctr_width()  : counter width for a given timeout (at least 1 bit)
//   pc_misaligned(): true when the low pc bits are not word aligned
package instr_fetch_pkg;

    typedef enum logic [3:0] {
        S_UNKNOWN   = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_WRITEBACK = 4'd4,
        S_EXCEPTION = 4'd5
    } ctx_state_t;

    typedef enum logic [4:0] {
        EX_NONE = 5'd0,
        EX_ADEL = 5'd4,
        EX_ADES = 5'd5
    } exc_code_t;

    typedef struct packed {
        exc_code_t code;
    } exception_t;

    typedef struct packed {
        logic [31:0] imm;
        exception_t  exception;
    } args_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        ctx_state_t       state;
        logic [1:0][31:0] r;
        args_t            args;
    } context_t;

    // A zero timeout still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned ctr_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Handshake and instruction-bus bundle of the fetch stage.
//   master : the fetch stage itself (drives in_ready, ireq_*, out_*)
//   slave  : its surroundings (upstream producer, instruction bus, downstream)
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic        in_valid;
    logic        in_ready;
    context_t    ctx;

    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    logic        out_valid;
    logic        out_ready;
    context_t    out;

    modport master (
        input  in_valid, ctx, iresp_addr_ok, iresp_data_ok, iresp_data, out_ready,
        output in_ready, ireq_valid, ireq_addr, out_valid, out
    );

    modport slave (
        output in_valid, ctx, iresp_addr_ok, iresp_data_ok, iresp_data, out_ready,
        input  in_ready, ireq_valid, ireq_addr, out_valid, out
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the fetch stage's data phase.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : clear (asserted on entry to the data-wait state)
//   i_inc      : count this cycle (asserted while waiting for data)
//   o_expired  : this wait cycle is the TIMEOUT-th one; never set if TIMEOUT==0
module fetch_timeout_ctr
    import instr_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CW = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // The count holds the number of wait cycles already finished, so the
    // increment in the cycle where it equals TIMEOUT-1 is the one that
    // reaches TIMEOUT.
    assign o_expired = (TIMEOUT != 0) && i_inc && (r_count == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetch stage.
// Takes one context in S_FETCH, reads the word at ctx.pc over the instruction
// bus, stores it in ctx.instr and hands the context on in S_DECODE.
// Misaligned pc -> S_EXCEPTION/EX_ADEL without touching the bus.
// No data within TIMEOUT wait cycles -> S_UNKNOWN, and the late response is
// dropped before another request is issued.
//   clk, reset : clock, synchronous active-high reset
//   bus        : in_* (context in), ireq_*/iresp_* (instruction bus),
//                out_* (context out), all registered on the stage side
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_HOLD = 2'd3
    } fetch_state_t;

    fetch_state_t r_state;
    context_t     r_ctx;
    logic         r_in_ready;
    logic         r_ireq_valid;
    logic         r_out_valid;
    logic         r_drain;

    logic w_ctr_clr;
    logic w_ctr_inc;
    logic w_expired;
    logic w_drain_clr;

    assign w_ctr_clr   = (r_state == F_REQ) && bus.iresp_addr_ok;
    assign w_ctr_inc   = (r_state == F_WAIT);
    // The first data_ok after a timeout belongs to the abandoned request.
    assign w_drain_clr = r_drain && bus.iresp_data_ok;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_ctr_clr),
        .i_inc     (w_ctr_inc),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= F_IDLE;
            r_ctx        <= '0;
            r_in_ready   <= 1'b1;
            r_ireq_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_drain      <= 1'b0;
        end else begin
            if (w_drain_clr) begin
                r_drain <= 1'b0;
            end

            unique case (r_state)
                F_IDLE: begin
                    if (r_in_ready && bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_ctx      <= bus.ctx;
                        if (pc_misaligned(bus.ctx.pc[1:0])) begin
                            r_ctx.state               <= S_EXCEPTION;
                            r_ctx.args.exception.code <= EX_ADEL;
                            r_out_valid               <= 1'b1;
                            r_state                   <= F_HOLD;
                        end else begin
                            r_ireq_valid <= 1'b1;
                            r_state      <= F_REQ;
                        end
                    end else begin
                        // Stay closed until any outstanding late response is gone.
                        r_in_ready <= !r_drain || w_drain_clr;
                    end
                end

                F_REQ: begin
                    if (bus.iresp_addr_ok) begin
                        r_ireq_valid <= 1'b0;
                        if (bus.iresp_data_ok) begin
                            r_ctx.instr <= bus.iresp_data;
                            r_ctx.state <= S_DECODE;
                            r_out_valid <= 1'b1;
                            r_state     <= F_HOLD;
                        end else begin
                            r_state <= F_WAIT;
                        end
                    end
                end

                F_WAIT: begin
                    // Data arriving in the expiring cycle still wins.
                    if (bus.iresp_data_ok) begin
                        r_ctx.instr <= bus.iresp_data;
                        r_ctx.state <= S_DECODE;
                        r_out_valid <= 1'b1;
                        r_state     <= F_HOLD;
                    end else if (w_expired) begin
                        r_ctx.state <= S_UNKNOWN;
                        r_drain     <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= F_HOLD;
                    end
                end

                F_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= F_IDLE;
                        r_in_ready  <= !r_drain || w_drain_clr;
                    end
                end

                default: r_state <= F_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.ireq_valid = r_ireq_valid;
    assign bus.ireq_addr  = r_ctx.pc;
    assign bus.out_valid  = r_out_valid;
    assign bus.out        = r_ctx;

endmodule
